// File: rtl/aes_iter_core_if.sv
// Block handshake bundle for aes_iter_core: input offer and registered result.
interface aes_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_decrypt;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_decrypt;

    modport master (
        output in_valid, in_decrypt, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_decrypt
    );

    modport slave (
        input  in_valid, in_decrypt, in_data, out_ready,
        output in_ready, out_valid, out_data, out_decrypt
    );
endinterface

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 core: one cipher round per clock, per-block encrypt or decrypt.
// The round-key schedule comes fully expanded from the key-expansion block.
module aes_iter_core #(
    parameter int NK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [127:0]   k_sch [0:NK+6],
    aes_iter_core_if.slave bus,
    output logic           busy
);
    localparam int NR = NK + 6;
    localparam int CW = $clog2(NR + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRound = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    // Byte x of each table lives at bits [8*(255-x)+7 -: 8], i.e. index {~x, 3'b111}.
    localparam logic [2047:0] Sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? InvSbox[{~s[8*i +: 8], 3'b111} -: 8]
                              : Sbox[{~s[8*i +: 8], 3'b111} -: 8];
        end
        return r;
    endfunction

    // Byte (row, col) sits at bits [127 - 8*(row + 4*col) -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        int src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                src = inv ? (c - w + 4) % 4 : (c + w) % 4;
                r[127 - 8*(w + 4*c) -: 8] = s[127 - 8*(w + 4*src) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                a[k]  = s[127 - 32*c - 8*k -: 8];
                m2[k] = xtime(a[k]);
                m4[k] = xtime(m2[k]);
                m8[k] = xtime(m4[k]);
            end
            for (int k = 0; k < 4; k++) begin
                if (inv) begin
                    // {0e, 0b, 0d, 09} circulant
                    r[127 - 32*c - 8*k -: 8] = (m8[k] ^ m4[k] ^ m2[k])
                        ^ (m8[(k+1)%4] ^ m2[(k+1)%4] ^ a[(k+1)%4])
                        ^ (m8[(k+2)%4] ^ m4[(k+2)%4] ^ a[(k+2)%4])
                        ^ (m8[(k+3)%4] ^ a[(k+3)%4]);
                end else begin
                    r[127 - 32*c - 8*k -: 8] = m2[k] ^ m2[(k+1)%4] ^ a[(k+1)%4]
                        ^ a[(k+2)%4] ^ a[(k+3)%4];
                end
            end
        end
        return r;
    endfunction

    logic [1:0]    fsm_q, fsm_d;
    logic [CW-1:0] round_q, round_d;
    logic [127:0]  blk_q, blk_d;
    logic          mode_q, mode_d;
    logic          out_valid_q, out_valid_d;

    logic          in_ready;
    logic          load;
    logic          last;
    logic [CW-1:0] dec_idx;
    logic [127:0]  enc_sr, enc_next, dec_xk, dec_next;

    assign in_ready = (fsm_q == StIdle) || ((fsm_q == StDone) && bus.out_ready);
    assign load     = bus.in_valid && in_ready;
    assign last     = (round_q == CW'(NR));
    assign dec_idx  = CW'(NR) - round_q;

    assign enc_sr   = shift_rows(sub_bytes(blk_q, 1'b0), 1'b0);
    assign enc_next = (last ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ k_sch[round_q];
    assign dec_xk   = sub_bytes(shift_rows(blk_q, 1'b1), 1'b1) ^ k_sch[dec_idx];
    assign dec_next = last ? dec_xk : mix_columns(dec_xk, 1'b1);

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        blk_d       = blk_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            StIdle: ;
            StRound: begin
                blk_d = mode_q ? dec_next : enc_next;
                if (last) begin
                    fsm_d       = StDone;
                    out_valid_d = 1'b1;
                end else begin
                    round_d = round_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    fsm_d       = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: fsm_d = StIdle;
        endcase
        // A load in DONE consumes the held result on the same edge.
        if (load) begin
            mode_d      = bus.in_decrypt;
            blk_d       = bus.in_data ^ (bus.in_decrypt ? k_sch[NR] : k_sch[0]);
            round_d     = CW'(1);
            fsm_d       = StRound;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= StIdle;
            round_q     <= '0;
            blk_q       <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            blk_q       <= blk_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = blk_q;
    assign bus.out_decrypt = mode_q;
    assign busy            = (fsm_q == StRound);
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES block cipher core, one round per clock, parametrised for AES-128/192/256.
Per-block encrypt or decrypt, selected at accept time.
Valid/ready handshakes on input and output, with a registered result held under backpressure.
Sits between the key-expansion block, which supplies the full round-key schedule, and the stream/mode wrappers.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8.
- NR, NK+6, number of rounds; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- k_sch  in  128 x [0:NR]  round keys in encryption order; k_sch[0] is the cipher key prefix.
- in_valid  in  1  input block offered.
- in_ready  out  1  core can accept a block this cycle.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
- in_data  in  128  plaintext or ciphertext; FIPS-197 byte 0 at [127:120], column-major.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  128  result, same byte order as in_data.
- out_decrypt  out  1  mode of the block on out_data.
- busy  out  1  high in ROUND.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; round counter = 0; state register = 0.
  - out_valid = 0; out_data = 0; out_decrypt = 0; busy = 0.
  - Deassertion is synchronised externally.
- FSM states: IDLE, ROUND, DONE.
- in_ready = (IDLE) or (DONE and out_ready). It is combinational from the FSM and out_ready only, never from in_valid.
- Accept occurs when in_valid & in_ready at an edge:
  - mode register <= in_decrypt.
  - state <= in_data ^ k_sch[0] for encrypt, or in_data ^ k_sch[NR] for decrypt.
  - round counter <= 1; FSM -> ROUND.
- ROUND, one round per edge, round counter r:
  - Encrypt, r<NR: state <= MixColumns(ShiftRows(SubBytes(state))) ^ k_sch[r].
  - Encrypt, r=NR: state <= ShiftRows(SubBytes(state)) ^ k_sch[NR] (no MixColumns).
  - Decrypt, r<NR: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k_sch[NR-r]).
  - Decrypt, r=NR: state <= InvSubBytes(InvShiftRows(state)) ^ k_sch[0] (no InvMixColumns).
  - When r=NR: FSM -> DONE; out_valid <= 1. Otherwise r <= r+1.
- Latency: out_valid rises NR edges after the accept edge (10/12/14).
- Throughput: one block per NR+1 cycles with out_ready tied high.
- out_data is the state register directly; out_decrypt is the mode register.
- DONE:
  - Hold out_valid, out_data and out_decrypt stable until out_ready.
  - On out_ready & ~in_valid: FSM -> IDLE; out_valid <= 0.
  - On out_ready & in_valid (simultaneous drain + accept): the result is consumed and the new block loads on the same edge. FSM -> ROUND; out_valid <= 0. No bubble cycle.
- in_valid in ROUND is ignored (in_ready = 0). The source must hold in_data and in_decrypt until accepted.
- k_sch must be stable from the accept edge through the edge that sets out_valid; behaviour is undefined otherwise.
- Round counter width: $clog2(NR+1). It never exceeds NR and never wraps.
- Reset mid-ROUND or in DONE: the block in flight is discarded and no output is produced. The core is ready (in_ready=1) on the first edge after reset release.
- Combinational path per cycle: one round (SubBytes/InvSubBytes via 256-entry const tables, GF(2^8) xtime). Decrypt uses the straightforward inverse cipher, not the equivalent inverse cipher.

Test Plan:
- AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, encrypt -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept, out_decrypt=0.
- AES-192 and AES-256 (C.2/C.3, NK=6/8), same pt, key 00..17 / 00..1f:
  - Encrypt -> dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089.
  - Latency 12 / 14 cycles.
- Decrypt, each NK: feed the C.x ciphertext with in_decrypt=1 -> 00112233445566778899aabbccddeeff, out_decrypt=1.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 throughout.
  - Raise out_ready with in_valid=1 on the same cycle -> next block accepted on that edge; out_valid low the next cycle and high again NR edges later with the correct value.
- Back-to-back mixed modes: in_valid and out_ready tied high, alternating encrypt/decrypt of the C.1 vectors, 8 blocks:
  - Every result correct and in order.
  - Accept period NR+1 = 11 cycles.
- Reset mid-operation: assert rst asynchronously (off clock edge) at round 5 -> out_valid=0 and out_data=0 immediately. After release, the next C.1 encrypt gives the correct result with no stale output.
